// File: rtl/mac_rx_pktbuf.sv
`default_nettype none
// ============================================================================
// Module  : mac_rx_pktbuf
// Brief   : RX packet buffer; packs words into RAM, commits or rolls back
//           frames, drains committed frames as a valid/ready word stream.
// Rev     : 1.0
// ============================================================================
module mac_rx_pktbuf #(
    parameter int ADDR_W    = 9,
    parameter int LEN_DEPTH = 4,
    parameter int LEN_W     = 11,
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1518
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             in_valid,
    input  logic [2:0]       in_bcnt,
    input  logic [31:0]      in_data,
    output logic             out_len_valid,
    output logic [LEN_W-1:0] out_len,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [2:0]       out_bcnt,
    output logic             out_last,
    input  logic             out_ready,
    input  logic             discard,
    input  logic             clr_cnt,
    output logic [15:0]      frm_cnt,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      err_cnt
);
    localparam int              c_DEPTH = 2**ADDR_W;
    localparam int              c_LW    = $clog2(LEN_DEPTH);
    localparam logic [ADDR_W:0] c_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W:0]  c_MIN   = (LEN_W+1)'(MIN_LEN);
    localparam logic [LEN_W:0]  c_MAX   = (LEN_W+1)'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_SKIP = 2'd2} wstate_t;
    wstate_t r_state, w_state_n;

    logic [31:0]      r_ram  [c_DEPTH];
    logic [LEN_W-1:0] r_lmem [LEN_DEPTH];

    logic [ADDR_W:0] r_wptr, r_whead, r_rptr, r_raddr, r_rem, w_wptr_n;
    logic [c_LW:0]   r_lwr, r_lrd, w_lcnt;
    logic [LEN_W:0]  r_acc, w_acc_n;
    logic            r_bad, r_ovf, r_gap;
    logic            w_take, w_dat, w_end, w_abort, w_full, w_wr, w_lfull;
    logic            w_bad_n, w_ovf_n, w_fend, w_commit;
    logic            w_inc_frm, w_inc_ovf, w_inc_err;
    logic            w_rel, w_load, w_fetch;
    logic [2:0]      w_lastb;

    function automatic logic [ADDR_W:0] f_words(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] w;
        w = ({1'b0, len} + (LEN_W+1)'(3)) >> 2;
        return (ADDR_W+1)'(w);
    endfunction

    function automatic logic [15:0] f_cnt(input logic [15:0] c, input logic inc, input logic clr);
        return clr ? 16'd0 : ((inc && c != 16'hFFFF) ? c + 16'd1 : c);
    endfunction

    assign w_lcnt  = r_lwr - r_lrd;
    assign w_lfull = (w_lcnt == (c_LW+1)'(LEN_DEPTH));
    assign w_lastb = (out_len[1:0] == 2'd0) ? 3'd4 : {1'b0, out_len[1:0]};

    // Write-side decode: a frame's first word is processed in IDLE when en is set
    always_comb begin
        w_take   = in_valid && ((r_state == S_RECV) || (r_state == S_IDLE && en));
        w_dat    = (in_bcnt != 3'd0) && (in_bcnt <= 3'd4);
        w_end    = (in_bcnt != 3'd4);
        w_abort  = (in_bcnt > 3'd4);
        w_full   = ((r_wptr - r_rptr) == c_FULL);
        w_wr     = w_take && w_dat && !r_bad && !w_full;
        w_wptr_n = r_wptr + (ADDR_W+1)'(w_wr);
        w_acc_n  = r_acc + (w_wr ? {{(LEN_W-2){1'b0}}, in_bcnt} : '0);
        w_bad_n  = r_bad;
        w_ovf_n  = r_ovf;
        if (w_take && !r_bad) begin
            if (w_dat && w_full) begin
                w_bad_n = 1'b1;
                w_ovf_n = 1'b1;
            end else if (w_abort || (w_acc_n > c_MAX)) begin
                w_bad_n = 1'b1;
                w_ovf_n = 1'b0;
            end
        end
        w_fend    = w_take && w_end;
        w_commit  = w_fend && !w_bad_n && (w_acc_n >= c_MIN) && !w_lfull;
        w_inc_frm = w_commit;
        w_inc_ovf = w_fend && (w_bad_n ? w_ovf_n : ((w_acc_n >= c_MIN) && w_lfull));
        w_inc_err = w_fend && (w_bad_n ? !w_ovf_n : (w_acc_n < c_MIN));

        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (in_valid && !w_end) w_state_n = en ? S_RECV : S_SKIP;
            S_RECV,
            S_SKIP:  if (in_valid && w_end) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (w_wr)     r_ram[r_wptr[ADDR_W-1:0]] <= in_data;
        if (w_commit) r_lmem[r_lwr[c_LW-1:0]]   <= w_acc_n[LEN_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_whead <= '0;
            r_acc   <= '0;
            r_bad   <= 1'b0;
            r_ovf   <= 1'b0;
            r_lwr   <= '0;
        end else if (w_fend) begin
            r_acc <= '0;
            r_bad <= 1'b0;
            r_ovf <= 1'b0;
            if (w_commit) begin
                r_wptr  <= w_wptr_n;
                r_whead <= w_wptr_n;
                r_lwr   <= r_lwr + (c_LW+1)'(1);
            end else begin
                r_wptr  <= r_whead;
            end
        end else begin
            r_acc  <= w_acc_n;
            r_bad  <= w_bad_n;
            r_ovf  <= w_ovf_n;
            r_wptr <= w_wptr_n;
        end
    end

    // The head stays in the length FIFO until released, so it occupies a slot
    assign w_rel   = (out_valid && out_ready && out_last) || (discard && out_len_valid);
    assign w_load  = !out_len_valid && !r_gap && (w_lcnt != '0);
    assign w_fetch = out_len_valid && (r_rem != '0) && (!out_valid || out_ready) && !discard;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_len_valid <= 1'b0;
            out_len       <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_bcnt      <= '0;
            out_last      <= 1'b0;
            r_rptr        <= '0;
            r_raddr       <= '0;
            r_rem         <= '0;
            r_lrd         <= '0;
            r_gap         <= 1'b0;
        end else begin
            r_gap <= w_rel;
            if (w_rel) begin
                out_len_valid <= 1'b0;
                out_valid     <= 1'b0;
                out_last      <= 1'b0;
                r_rem         <= '0;
                r_rptr        <= r_rptr + f_words(out_len);
                r_lrd         <= r_lrd + (c_LW+1)'(1);
            end else begin
                if (w_load) begin
                    out_len_valid <= 1'b1;
                    out_len       <= r_lmem[r_lrd[c_LW-1:0]];
                    r_raddr       <= r_rptr;
                    r_rem         <= f_words(r_lmem[r_lrd[c_LW-1:0]]);
                end
                if (w_fetch) begin
                    out_valid <= 1'b1;
                    out_data  <= r_ram[r_raddr[ADDR_W-1:0]];
                    out_last  <= (r_rem == (ADDR_W+1)'(1));
                    out_bcnt  <= (r_rem == (ADDR_W+1)'(1)) ? w_lastb : 3'd4;
                    r_raddr   <= r_raddr + (ADDR_W+1)'(1);
                    r_rem     <= r_rem - (ADDR_W+1)'(1);
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frm_cnt <= '0;
            ovf_cnt <= '0;
            err_cnt <= '0;
        end else begin
            frm_cnt <= f_cnt(frm_cnt, w_inc_frm, clr_cnt);
            ovf_cnt <= f_cnt(ovf_cnt, w_inc_ovf, clr_cnt);
            err_cnt <= f_cnt(err_cnt, w_inc_err, clr_cnt);
        end
    end
endmodule
`default_nettype wire
